mult_arbiter: RTL

Two-requester scheduler for the shared 8x8 sequential multiplier. It accepts operand pairs from two clients over valid/ready handshakes and arbitrates round-robin. It sequences the multiplier (start pulse, wait for done) and returns the 16-bit product to the owning client. It also detects multiplier error/hang and recovers the multiplier by resetting it.

---
 rtl/mult_pkg.sv | 19 +
 rtl/rr_arb2.sv | 18 +
 rtl/mult_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the multiplier scheduler.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Multiplier state_out codes of interest
    localparam logic [2:0] MULT_ST_DONE = 3'b100;
    localparam logic [2:0] MULT_ST_ERR  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to the client that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant_onehot,
    output logic       winner
);

    // Winner index and its one-hot grant (zero when nobody requests)
    always_comb begin
        winner       = (req == 2'b11) ? ~last_grant : req[1];
        grant_onehot = 2'b00;
        if (req != 2'b00)
            grant_onehot[winner] = 1'b1;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Scheduler for the shared 8x8 sequential multiplier: accepts operands
// from two clients, sequences start/done, detects error or hang and
// recovers the multiplier by pulsing its reset.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset_a_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [OP_W-1:0]     req_a0,
    input  logic [OP_W-1:0]     req_b0,
    input  logic [OP_W-1:0]     req_a1,
    input  logic [OP_W-1:0]     req_b1,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [PROD_W-1:0]   rsp_product,
    output logic                rsp_err,
    output logic                mult_start,
    output logic [OP_W-1:0]     mult_dataa,
    output logic [OP_W-1:0]     mult_datab,
    input  logic                mult_done,
    input  logic [PROD_W-1:0]   mult_product,
    input  logic [2:0]          mult_state,
    output logic                mult_reset_a,
    output logic                busy
);

    // WAIT ends on the cycle the counter would reach TIMEOUT
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_e state, state_nxt;
    logic       last_grant;
    logic       owner;
    logic [7:0] cnt;
    logic [1:0] grant;
    logic       winner;
    logic       accept;
    logic [1:0] owner_oh;

    rr_arb2 u_rr (
        .req          (req_valid),
        .last_grant   (last_grant),
        .grant_onehot (grant),
        .winner       (winner)
    );

    assign accept   = (state == ST_IDLE) && (req_valid != 2'b00);
    assign owner_oh = owner ? 2'b10 : 2'b01;

    // State register
    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; multiplier error outranks a same-cycle done
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mult_state == MULT_ST_ERR) state_nxt = ST_RECOVER;
                else if (mult_done)            state_nxt = ST_RESP;
                else if (cnt == CNT_LAST)      state_nxt = ST_RECOVER;
            end
            ST_RECOVER: state_nxt = ST_RESP;
            ST_RESP:    if (rsp_ready[owner]) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Combinational outputs: ready only while idle, busy otherwise
    always_comb begin
        req_ready = (state == ST_IDLE) ? grant : 2'b00;
        busy      = (state != ST_IDLE);
    end

    // Registered datapath: operand capture, pulses, timeout counter, response
    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= 8'd0;
            mult_start   <= 1'b0;
            mult_reset_a <= 1'b0;
            mult_dataa   <= '0;
            mult_datab   <= '0;
            rsp_valid    <= 2'b00;
            rsp_product  <= '0;
            rsp_err      <= 1'b0;
        end else begin
            mult_start   <= 1'b0;
            mult_reset_a <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mult_dataa <= winner ? req_a1 : req_a0;
                        mult_datab <= winner ? req_b1 : req_b0;
                        owner      <= winner;
                        last_grant <= winner;
                        mult_start <= 1'b1;
                    end
                end
                ST_ISSUE: cnt <= 8'd0;
                ST_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (state_nxt == ST_RESP) begin
                        rsp_product <= mult_product;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= owner_oh;
                    end else if (state_nxt == ST_RECOVER) begin
                        mult_reset_a <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    rsp_product <= '0;
                    rsp_err     <= 1'b1;
                    rsp_valid   <= owner_oh;
                end
                ST_RESP: if (state_nxt == ST_IDLE) rsp_valid <= 2'b00;
                default: ;
            endcase
        end
    end

endmodule
